mem_port_scheduler: RTL and testbench

- Shares one single-port memory bus between instruction fetch (IF) and the MEM stage's load/store, which is driven by the EX/MEM pipeline-register outputs.
- The bus uses a variable-latency req/ready handshake.
- The block sequences each access with an FSM and generates stall signals that freeze the pipeline registers until the access completes.
- Data accesses have priority over fetches.

---
 rtl/mem_port_scheduler_pkg.sv | 12 +
 rtl/mem_port_scheduler_access_timeout_counter.sv | 35 +++
 rtl/mem_port_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_scheduler_pkg.sv
// Shared definitions for the memory port scheduler: FSM encoding and defaults.
package mem_port_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } sched_state_e;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_scheduler_access_timeout_counter.sv
// Counts bus cycles spent waiting for ready and flags when the wait limit is hit.
module access_timeout_counter
    import mem_port_scheduler_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter; held at zero outside an access, saturates at the abort point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LAST_WAIT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The TIMEOUT-th not-ready cycle is the one that aborts the access.
    assign expired = enable && (cnt_r == LAST_WAIT);

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store,
// with data priority, pipeline stall generation and a bus-wait timeout.
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              stall_pipe,
    output logic              stall_fetch,
    output logic              timeout_err
);

    sched_state_e      state_r;
    sched_state_e      state_next_s;

    logic              data_op_s;
    logic              busy_s;
    logic              done_s;
    logic              cnt_en_s;
    logic              cnt_clr_s;
    logic              expired_s;
    logic [DATA_W-1:0] cpl_data_s;
    logic              stall_pipe_s;
    logic              stall_fetch_s;

    logic              bus_req_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [DATA_W-1:0] instr_r;
    logic              instr_valid_r;
    logic [DATA_W-1:0] load_data_r;
    logic              load_valid_r;
    logic              timeout_err_r;

    assign data_op_s = mem_read || mem_write;

    access_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clr_s),
        .enable  (cnt_en_s),
        .expired (expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: data wins in IDLE; an access ends on ready or timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (data_op_s) begin
                    state_next_s = ST_DATA;
                end else if (if_req) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA, ST_FETCH: begin
                if (done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: completion detect, timeout control and pipeline stalls.
    always_comb begin
        busy_s     = (state_r == ST_DATA) || (state_r == ST_FETCH);
        cnt_en_s   = busy_s && !bus_ready;
        cnt_clr_s  = !busy_s;
        done_s     = busy_s && (bus_ready || expired_s);
        cpl_data_s = bus_ready ? bus_rdata : '0;
        // A data op waiting behind an in-flight fetch keeps the pipe frozen too.
        stall_pipe_s = ((state_r == ST_IDLE)  && data_op_s) ||
                       ((state_r == ST_DATA)  && !done_s)   ||
                       ((state_r == ST_FETCH) && data_op_s);
        stall_fetch_s = stall_pipe_s ||
                        (if_req && ((state_r == ST_IDLE) || (state_r == ST_DATA) ||
                                    ((state_r == ST_FETCH) && !done_s)));
    end

    // Registered bus drive, completion capture and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= '0;
            bus_wdata_r   <= '0;
            instr_r       <= '0;
            instr_valid_r <= 1'b0;
            load_data_r   <= '0;
            load_valid_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            instr_valid_r <= 1'b0;
            load_valid_r  <= 1'b0;
            timeout_err_r <= timeout_err_r || expired_s;
            case (state_r)
                ST_IDLE: begin
                    if (data_op_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= mem_write;
                        bus_addr_r  <= mem_addr;
                        bus_wdata_r <= mem_wdata;
                    end else if (if_req) begin
                        bus_req_r  <= 1'b1;
                        bus_we_r   <= 1'b0;
                        bus_addr_r <= if_addr;
                    end else begin
                        bus_req_r <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (done_s) begin
                        bus_req_r    <= 1'b0;
                        load_valid_r <= 1'b1;
                        if (!bus_we_r) begin
                            load_data_r <= cpl_data_s;
                        end
                    end
                end
                ST_FETCH: begin
                    if (done_s) begin
                        bus_req_r     <= 1'b0;
                        instr_valid_r <= 1'b1;
                        instr_r       <= cpl_data_s;
                    end
                end
                default: bus_req_r <= 1'b0;
            endcase
        end
    end

    assign bus_req     = bus_req_r;
    assign bus_we      = bus_we_r;
    assign bus_addr    = bus_addr_r;
    assign bus_wdata   = bus_wdata_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign load_data   = load_data_r;
    assign load_valid  = load_valid_r;
    assign stall_pipe  = stall_pipe_s;
    assign stall_fetch = stall_fetch_s;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: fetch, load, collision, data-during-fetch,
// timeout and reset-mid-access scenarios with hand-computed expectations.
module tb_mem_port_scheduler;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall_pipe;
    logic        stall_fetch;
    logic        timeout_err;

    int compared;
    int mismatched;
    int n_req;

    mem_port_scheduler #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (255)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .stall_pipe  (stall_pipe),
        .stall_fetch (stall_fetch),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge so inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'h0;

        // Reset state
        #12;
        chk1 ("rst_bus_req",     bus_req,     1'b0);
        chk1 ("rst_bus_we",      bus_we,      1'b0);
        chk32("rst_bus_addr",    bus_addr,    32'h0);
        chk32("rst_bus_wdata",   bus_wdata,   32'h0);
        chk32("rst_instr",       instr,       32'h0);
        chk32("rst_load_data",   load_data,   32'h0);
        chk1 ("rst_instr_valid", instr_valid, 1'b0);
        chk1 ("rst_load_valid",  load_valid,  1'b0);
        chk1 ("rst_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Fetch only: 3 FETCH cycles, ready on the third
        tick(); if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk1("f_idle_stall_pipe",  stall_pipe,  1'b0);
        chk1("f_idle_stall_fetch", stall_fetch, 1'b1);
        chk1("f_idle_bus_req",     bus_req,     1'b0);
        tick();
        @(negedge clk);
        chk1 ("f_c1_bus_req",     bus_req,     1'b1);
        chk32("f_c1_bus_addr",    bus_addr,    32'h40);
        chk1 ("f_c1_bus_we",      bus_we,      1'b0);
        chk1 ("f_c1_stall_pipe",  stall_pipe,  1'b0);
        chk1 ("f_c1_stall_fetch", stall_fetch, 1'b1);
        tick();
        @(negedge clk);
        chk1("f_c2_bus_req", bus_req, 1'b1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h8C220004;
        @(negedge clk);
        chk1("f_c3_bus_req",     bus_req,     1'b1);
        chk1("f_c3_stall_fetch", stall_fetch, 1'b0);
        chk1("f_c3_stall_pipe",  stall_pipe,  1'b0);
        tick(); bus_ready = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk1 ("f_done_bus_req",     bus_req,     1'b0);
        chk1 ("f_done_instr_valid", instr_valid, 1'b1);
        chk32("f_done_instr",       instr,       32'h8C220004);
        tick();
        @(negedge clk);
        chk1("f_after_instr_valid", instr_valid, 1'b0);

        // Load: ready on the first DATA cycle
        tick(); mem_read = 1'b1; mem_addr = 32'h100;
        @(negedge clk);
        chk1("ld_idle_stall_pipe", stall_pipe, 1'b1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h1234;
        @(negedge clk);
        chk1 ("ld_data_stall_pipe", stall_pipe, 1'b0);
        chk1 ("ld_data_bus_req",    bus_req,    1'b1);
        chk32("ld_data_bus_addr",   bus_addr,   32'h100);
        chk1 ("ld_data_bus_we",     bus_we,     1'b0);
        tick(); mem_read = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk1 ("ld_done_load_valid", load_valid, 1'b1);
        chk32("ld_done_load_data",  load_data,  32'h1234);
        chk1 ("ld_done_bus_req",    bus_req,    1'b0);
        tick();
        @(negedge clk);
        chk1("ld_after_load_valid", load_valid, 1'b0);

        // Collision: write and fetch in the same cycle, write wins
        tick(); if_req = 1'b1; if_addr = 32'h80;
        mem_write = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hCAFE;
        @(negedge clk);
        chk1("col_idle_stall_pipe",  stall_pipe,  1'b1);
        chk1("col_idle_stall_fetch", stall_fetch, 1'b1);
        tick();
        @(negedge clk);
        chk1 ("col_w1_bus_we",      bus_we,      1'b1);
        chk32("col_w1_bus_wdata",   bus_wdata,   32'hCAFE);
        chk32("col_w1_bus_addr",    bus_addr,    32'h200);
        chk1 ("col_w1_stall_pipe",  stall_pipe,  1'b1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'hDEAD;
        @(negedge clk);
        chk1("col_w2_stall_pipe",  stall_pipe,  1'b0);
        chk1("col_w2_stall_fetch", stall_fetch, 1'b1);
        tick(); mem_write = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk1 ("col_st_load_valid",   load_valid,  1'b1);
        chk32("col_st_load_data",    load_data,   32'h1234);
        chk1 ("col_gap_bus_req",     bus_req,     1'b0);
        chk1 ("col_gap_stall_fetch", stall_fetch, 1'b1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h11112222;
        @(negedge clk);
        chk1 ("col_f_bus_req",     bus_req,     1'b1);
        chk1 ("col_f_bus_we",      bus_we,      1'b0);
        chk32("col_f_bus_addr",    bus_addr,    32'h80);
        chk1 ("col_f_stall_fetch", stall_fetch, 1'b0);
        tick(); if_req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk1 ("col_f_instr_valid", instr_valid, 1'b1);
        chk32("col_f_instr",       instr,       32'h11112222);

        // Data arriving during a fetch waits for the fetch to finish
        tick(); if_req = 1'b1; if_addr = 32'h44;
        tick(); mem_read = 1'b1; mem_addr = 32'h300;
        @(negedge clk);
        chk32("dxf_f1_bus_addr",   bus_addr,   32'h44);
        chk1 ("dxf_f1_stall_pipe", stall_pipe, 1'b1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'hAAAA;
        @(negedge clk);
        chk1("dxf_f2_stall_pipe",  stall_pipe,  1'b1);
        chk1("dxf_f2_stall_fetch", stall_fetch, 1'b1);
        tick(); if_req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk1 ("dxf_idle_instr_valid", instr_valid, 1'b1);
        chk32("dxf_idle_instr",       instr,       32'hAAAA);
        chk1 ("dxf_idle_stall_pipe",  stall_pipe,  1'b1);
        chk1 ("dxf_idle_bus_req",     bus_req,     1'b0);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h5555;
        @(negedge clk);
        chk1 ("dxf_d_bus_req",    bus_req,    1'b1);
        chk32("dxf_d_bus_addr",   bus_addr,   32'h300);
        chk1 ("dxf_d_stall_pipe", stall_pipe, 1'b0);
        tick(); mem_read = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk1 ("dxf_ld_valid", load_valid, 1'b1);
        chk32("dxf_ld_data",  load_data,  32'h5555);

        // Timeout: ready never comes, abort after 255 DATA cycles
        tick(); mem_read = 1'b1; mem_addr = 32'h400; bus_rdata = 32'hFFFF;
        n_req = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            @(negedge clk);
            if (bus_req) n_req++;
            if (!stall_pipe) break;
        end
        chk32("to_data_cycles",  32'(n_req),  32'd255);
        chk1 ("to_err_before",   timeout_err, 1'b0);
        tick(); mem_read = 1'b0;
        @(negedge clk);
        chk1 ("to_err",         timeout_err, 1'b1);
        chk1 ("to_load_valid",  load_valid,  1'b1);
        chk32("to_load_data",   load_data,   32'h0);
        chk1 ("to_bus_req",     bus_req,     1'b0);
        chk1 ("to_stall_pipe",  stall_pipe,  1'b0);
        chk1 ("to_stall_fetch", stall_fetch, 1'b0);
        tick();
        @(negedge clk);
        chk1("to_err_sticky", timeout_err, 1'b1);

        // Reset asserted in the middle of a data access
        tick(); mem_read = 1'b1; mem_addr = 32'h500;
        tick();
        @(negedge clk);
        chk1("rm_data_bus_req", bus_req, 1'b1);
        #1; reset = 1'b0;
        #1;
        chk1("rm_async_bus_req",  bus_req,     1'b0);
        chk1("rm_err_cleared",    timeout_err, 1'b0);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk1("rm_no_load_valid", load_valid,  1'b0);
        chk1("rm_bus_req",       bus_req,     1'b0);
        chk1("rm_stall_pipe",    stall_pipe,  1'b0);
        chk1("rm_stall_fetch",   stall_fetch, 1'b0);
        // IDLE after reset: a new fetch is accepted immediately
        tick(); if_req = 1'b1; if_addr = 32'h60;
        tick();
        @(negedge clk);
        chk1 ("rm_fetch_bus_req",  bus_req,  1'b1);
        chk32("rm_fetch_bus_addr", bus_addr, 32'h60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
